// File: rtl/mouse_pos_sync.sv
// Mouse position synchroniser: holds the latest mouse sample and commits it to the
// cursor overlay once per frame, at the start of vertical blanking.
module mouse_pos_sync #(
    parameter int XMAX = 799,
    parameter int YMAX = 599
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] xpos_in,
    input  logic [11:0] ypos_in,
    input  logic        left_in,
    input  logic        vblnk_in,
    output logic [11:0] xpos_out,
    output logic [11:0] ypos_out,
    output logic        left_out,
    output logic        left_click,
    output logic        frame_upd
);

    localparam logic [11:0] XMAX_C = 12'(XMAX);
    localparam logic [11:0] YMAX_C = 12'(YMAX);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        COMMIT
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] pend_x_q, pend_x_d;
    logic [11:0] pend_y_q, pend_y_d;
    logic        pend_left_q, pend_left_d;
    logic [11:0] xpos_q, xpos_d;
    logic [11:0] ypos_q, ypos_d;
    logic        left_q, left_d;
    logic        left_click_q, left_click_d;
    logic        frame_upd_q, frame_upd_d;
    logic        in_ready_q, in_ready_d;
    logic        vblnk_prev_q, vblnk_prev_d;
    logic        accept;
    logic        vblank_start;

    assign accept       = in_valid & in_ready_q;
    assign vblank_start = vblnk_in & ~vblnk_prev_q;

    always_comb begin
        state_d      = state_q;
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        pend_left_d  = pend_left_q;
        xpos_d       = xpos_q;
        ypos_d       = ypos_q;
        left_d       = left_q;
        left_click_d = 1'b0;
        frame_upd_d  = 1'b0;
        vblnk_prev_d = vblnk_in;

        // A sample accepted on the vblank-start edge still lands in the pending
        // registers, so it is the one transferred in the following COMMIT cycle.
        if (accept) begin
            pend_x_d    = (xpos_in > XMAX_C) ? XMAX_C : xpos_in;
            pend_y_d    = (ypos_in > YMAX_C) ? YMAX_C : ypos_in;
            pend_left_d = left_in;
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = PEND;
            end
            PEND: begin
                if (vblank_start) state_d = COMMIT;
            end
            COMMIT: begin
                xpos_d       = pend_x_q;
                ypos_d       = pend_y_q;
                left_d       = pend_left_q;
                frame_upd_d  = 1'b1;
                left_click_d = pend_left_q & ~left_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d != COMMIT);
    end

    // Previous-vblank resets high so a vblank already active at release is not a start.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            pend_left_q  <= 1'b0;
            xpos_q       <= '0;
            ypos_q       <= '0;
            left_q       <= 1'b0;
            left_click_q <= 1'b0;
            frame_upd_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            vblnk_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            pend_left_q  <= pend_left_d;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
            left_q       <= left_d;
            left_click_q <= left_click_d;
            frame_upd_q  <= frame_upd_d;
            in_ready_q   <= in_ready_d;
            vblnk_prev_q <= vblnk_prev_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign xpos_out   = xpos_q;
    assign ypos_out   = ypos_q;
    assign left_out   = left_q;
    assign left_click = left_click_q;
    assign frame_upd  = frame_upd_q;

endmodule

// File: tb/tb_mouse_pos_sync.sv
// Directed bench for mouse_pos_sync: predicted commits go into a scoreboard queue
// and are checked whenever the DUT pulses frame_upd.
module tb_mouse_pos_sync;

    logic        pclk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] xpos_in;
    logic [11:0] ypos_in;
    logic        left_in;
    logic        vblnk_in;
    logic [11:0] xpos_out;
    logic [11:0] ypos_out;
    logic        left_out;
    logic        left_click;
    logic        frame_upd;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic        l;
        logic        c;
    } commit_t;

    commit_t     sb[$];
    int          nAsserts = 0;
    int          nFails   = 0;
    logic [11:0] pendX;
    logic [11:0] pendY;
    logic        pendL;
    logic        havePend;
    logic        lastLeft;

    mouse_pos_sync #(.XMAX(799), .YMAX(599)) dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .xpos_in   (xpos_in),
        .ypos_in   (ypos_in),
        .left_in   (left_in),
        .vblnk_in  (vblnk_in),
        .xpos_out  (xpos_out),
        .ypos_out  (ypos_out),
        .left_out  (left_out),
        .left_click(left_click),
        .frame_upd (frame_upd)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    function automatic logic [11:0] clampTo(input logic [11:0] v, input logic [11:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // One accepted sample; the bench tracks what should now be pending.
    task automatic applyStimulus(input logic [11:0] x, input logic [11:0] y, input logic l);
        checkBit("ready_before_sample", in_ready, 1'b1);
        in_valid = 1'b1;
        xpos_in  = x;
        ypos_in  = y;
        left_in  = l;
        tick();
        in_valid = 1'b0;
        pendX    = clampTo(x, 12'd799);
        pendY    = clampTo(y, 12'd599);
        pendL    = l;
        havePend = 1'b1;
    endtask

    task automatic pushCommit();
        commit_t e;
        e.x = pendX;
        e.y = pendY;
        e.l = pendL;
        e.c = pendL & ~lastLeft;
        sb.push_back(e);
        lastLeft = pendL;
    endtask

    task automatic doVblank();
        logic expectCommit;
        logic [11:0] oldX;
        expectCommit = havePend;
        oldX = xpos_out;
        if (expectCommit) pushCommit();
        vblnk_in = 1'b1;
        tick();
        checkBit("upd_after_vblank_edge", frame_upd, 1'b0);
        checkOutput("x_held_until_commit", xpos_out, oldX);
        tick();
        checkBit("upd_two_cycles_after", frame_upd, expectCommit);
        if (expectCommit) begin
            checkOutput("x_committed", xpos_out, pendX);
            checkOutput("y_committed", ypos_out, pendY);
        end else begin
            checkOutput("x_unchanged_no_pend", xpos_out, oldX);
        end
        tick();
        checkBit("upd_single_cycle", frame_upd, 1'b0);
        vblnk_in = 1'b0;
        tick();
        havePend = 1'b0;
    endtask

    always @(negedge pclk) begin
        if (frame_upd === 1'b1) begin
            if (sb.size() == 0) begin
                checkBit("upd_without_prediction", frame_upd, 1'b0);
            end else begin
                commit_t e;
                e = sb.pop_front();
                checkOutput("sb_x", xpos_out, e.x);
                checkOutput("sb_y", ypos_out, e.y);
                checkBit("sb_left", left_out, e.l);
                checkBit("sb_click", left_click, e.c);
            end
        end else begin
            checkBit("click_without_upd", left_click, 1'b0);
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        xpos_in  = '0;
        ypos_in  = '0;
        left_in  = 1'b0;
        vblnk_in = 1'b0;
        pendX    = '0;
        pendY    = '0;
        pendL    = 1'b0;
        havePend = 1'b0;
        lastLeft = 1'b0;

        tick();
        tick();
        checkBit("reset_ready", in_ready, 1'b0);
        checkOutput("reset_x", xpos_out, 12'd0);
        checkOutput("reset_y", ypos_out, 12'd0);
        checkBit("reset_left", left_out, 1'b0);
        checkBit("reset_upd", frame_upd, 1'b0);
        rst_n = 1'b1;
        tick();
        checkBit("ready_after_release", in_ready, 1'b1);
        tick();

        $display("[TB] basic commit");
        applyStimulus(12'd100, 12'd50, 1'b0);
        checkBit("ready_in_pend", in_ready, 1'b1);
        doVblank();

        $display("[TB] latest sample wins");
        applyStimulus(12'd10, 12'd10, 1'b0);
        applyStimulus(12'd20, 12'd20, 1'b0);
        applyStimulus(12'd30, 12'd30, 1'b0);
        doVblank();

        $display("[TB] clamping");
        applyStimulus(12'd4095, 12'd700, 1'b0);
        doVblank();
        checkOutput("clamp_x_max", xpos_out, 12'd799);
        checkOutput("clamp_y_max", ypos_out, 12'd599);
        applyStimulus(12'd799, 12'd599, 1'b0);
        doVblank();
        applyStimulus(12'd800, 12'd4095, 1'b0);
        checkOutput("stable_mid_frame", xpos_out, 12'd799);
        doVblank();
        applyStimulus(12'd798, 12'd598, 1'b0);
        doVblank();

        $display("[TB] left click edges");
        applyStimulus(12'd5, 12'd6, 1'b0);
        doVblank();
        applyStimulus(12'd7, 12'd8, 1'b1);
        doVblank();
        applyStimulus(12'd9, 12'd10, 1'b1);
        doVblank();
        applyStimulus(12'd11, 12'd12, 1'b0);
        doVblank();
        applyStimulus(12'd13, 12'd14, 1'b1);
        applyStimulus(12'd15, 12'd16, 1'b0);
        doVblank();

        $display("[TB] sample on vblank edge, sample during commit");
        applyStimulus(12'd1, 12'd1, 1'b0);
        vblnk_in = 1'b1;
        in_valid = 1'b1;
        xpos_in  = 12'd2;
        ypos_in  = 12'd2;
        left_in  = 1'b1;
        pendX    = 12'd2;
        pendY    = 12'd2;
        pendL    = 1'b1;
        pushCommit();
        tick();
        checkBit("ready_in_commit", in_ready, 1'b0);
        xpos_in  = 12'd3;
        ypos_in  = 12'd3;
        left_in  = 1'b0;
        tick();
        in_valid = 1'b0;
        checkBit("edge_sample_upd", frame_upd, 1'b1);
        checkOutput("edge_sample_x", xpos_out, 12'd2);
        checkBit("edge_sample_click", left_click, 1'b1);
        checkBit("ready_after_commit", in_ready, 1'b1);
        tick();
        vblnk_in = 1'b0;
        tick();
        havePend = 1'b0;
        doVblank();
        checkOutput("dropped_sample_x", xpos_out, 12'd2);

        $display("[TB] reset while pending");
        applyStimulus(12'd200, 12'd200, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_x", xpos_out, 12'd0);
        checkBit("async_reset_ready", in_ready, 1'b0);
        tick();
        rst_n    = 1'b1;
        havePend = 1'b0;
        lastLeft = 1'b0;
        tick();
        doVblank();
        checkOutput("post_reset_x", xpos_out, 12'd0);
        checkOutput("post_reset_y", ypos_out, 12'd0);
        checkBit("post_reset_left", left_out, 1'b0);

        repeat (4) tick();
        checkOutput("sb_drained", 12'(sb.size()), 12'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/mouse_pos_sync.md
MOUSE_POS_SYNC -- requirements
Module: mouse_pos_sync

Interface
REQ-001 Parameter XMAX, default 799: largest legal committed x coordinate.
REQ-002 Parameter YMAX, default 599: largest legal committed y coordinate.
REQ-003 Port pclk, input, 1: pixel clock; the only clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset; deassertion is synchronous to pclk.
REQ-005 Port in_valid, input, 1: a mouse sample is offered this cycle.
REQ-006 Port in_ready, output, 1: the block accepts a sample this cycle.
REQ-007 Port xpos_in, input, 12: raw mouse x, unsigned.
REQ-008 Port ypos_in, input, 12: raw mouse y, unsigned.
REQ-009 Port left_in, input, 1: raw left-button level.
REQ-010 Port vblnk_in, input, 1: vertical blanking from VGA timing, pclk domain.
REQ-011 Port xpos_out, output, 12: committed x, stable for a whole frame, feeds the cursor overlay stage.
REQ-012 Port ypos_out, output, 12: committed y, stable for a whole frame.
REQ-013 Port left_out, output, 1: committed left-button level.
REQ-014 Port left_click, output, 1: one-cycle pulse on a committed 0->1 left transition.
REQ-015 Port frame_upd, output, 1: one-cycle pulse marking each commit.

Function
REQ-016 A sample SHALL be accepted only on a pclk edge where in_valid=1 and in_ready=1.
REQ-017 On acceptance, x SHALL be stored as min(xpos_in, XMAX), y as min(ypos_in, YMAX), and left as left_in, into pending registers.
REQ-018 The FSM SHALL have three states: IDLE (nothing pending), PEND (sample held), COMMIT (one-cycle transfer).
REQ-019 The FSM SHALL move IDLE->PEND on acceptance and stay in IDLE otherwise.
REQ-020 In PEND, a further accepted sample SHALL overwrite the pending registers (latest wins) and the FSM SHALL stay in PEND.
REQ-021 vblank start SHALL be detected as vblnk_in=1 with the registered previous value of vblnk_in equal to 0.
REQ-022 On a vblank start in PEND, the FSM SHALL go to COMMIT.
REQ-023 If acceptance and vblank start happen in the same PEND cycle, the new sample SHALL be latched first and then committed.
REQ-024 In COMMIT, outputs SHALL load from the pending registers on the exit edge, frame_upd SHALL be 1 for that cycle only, and the FSM SHALL return to IDLE.
REQ-025 in_ready SHALL be 0 in COMMIT and 1 in IDLE and PEND.
REQ-026 A vblank start seen in IDLE or COMMIT SHALL be ignored.
REQ-027 Committed outputs SHALL be available two cycles after the vblank-start edge, with no further change until the next commit.
REQ-028 left_click SHALL pulse together with frame_upd when the new left_out=1 and the previous left_out=0.
REQ-029 A press and release both inside one frame SHALL produce no click (the latest sample wins).
REQ-030 Clamping SHALL compare full 12-bit unsigned values; 4095 SHALL clamp to XMAX or YMAX.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 While rst_n=0: state=IDLE; xpos_out=0, ypos_out=0, left_out=0, left_click=0, frame_upd=0; pending registers=0; previous-vblank register=1, so a vblank that is already high at release does not count as a start.
REQ-033 Reset asserted mid-PEND or mid-COMMIT SHALL discard the pending sample immediately, with no commit pulse.
REQ-034 in_ready SHALL be 0 during reset and 1 in the first cycle after release.

Verification
REQ-035 Reset release, then sample (100,50,left=0), then vblnk_in rises -> two cycles later xpos_out=100, ypos_out=50, frame_upd pulses once, left_click=0.
REQ-036 Samples (10,10), (20,20), (30,30) in one frame, then vblank -> only (30,30) is committed, with exactly one frame_upd.
REQ-037 Sample (4095,700) -> committed (799,599); sample (799,599) -> unchanged.
REQ-038 Frame N commits left=0 and frame N+1 commits left=1 -> left_click pulses exactly one cycle at the second commit; the same level in frame N+2 -> no pulse.
REQ-039 in_valid=1 on the same edge as vblank start while in PEND -> the new sample is committed; in_valid during COMMIT -> in_ready=0 and the sample is dropped.
REQ-040 rst_n pulsed low while in PEND with (200,200) pending, then vblank -> outputs stay 0 and frame_upd never asserts.
